// File: rtl/qed_pkg.sv
// Shared constants, decode helpers and remap function for the SQED instruction duplicator.
// Everything here is pure and synthesizable; the top and the FIFO import it.
package qed_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;

    localparam logic [31:0] QED_NOP = 32'h0000_0013;

    localparam int REG_W   = 5;
    localparam int RD_LSB  = 7;
    localparam int RS1_LSB = 15;
    localparam int RS2_LSB = 20;

    // Bit 4 of a register field selects the upper register half.
    localparam int HALF_BIT = REG_W - 1;

    typedef enum logic [1:0] {
        FMT_NONE,
        FMT_R,
        FMT_I,
        FMT_S
    } qed_fmt_e;

    typedef enum logic [1:0] {
        ACT_HOLD,
        ACT_PUSH,
        ACT_POP,
        ACT_BUBBLE
    } qed_act_e;

    function automatic qed_fmt_e qed_fmt(input logic [31:0] instr);
        qed_fmt_e fmt;
        case (instr[6:0])
            OPC_OP:               fmt = FMT_R;
            OPC_OP_IMM, OPC_LOAD: fmt = FMT_I;
            OPC_STORE:            fmt = FMT_S;
            default:              fmt = FMT_NONE;
        endcase
        return fmt;
    endfunction

    function automatic logic qed_uses_rd(input qed_fmt_e fmt);
        return (fmt == FMT_R) || (fmt == FMT_I);
    endfunction

    function automatic logic qed_uses_rs1(input qed_fmt_e fmt);
        return fmt != FMT_NONE;
    endfunction

    function automatic logic qed_uses_rs2(input qed_fmt_e fmt);
        return (fmt == FMT_R) || (fmt == FMT_S);
    endfunction

    function automatic logic qed_is_legal_orig(input logic [31:0] instr);
        qed_fmt_e fmt;
        logic     legal;
        fmt   = qed_fmt(instr);
        legal = qed_uses_rs1(fmt);
        if (qed_uses_rd(fmt) && instr[RD_LSB + HALF_BIT]) begin
            legal = 1'b0;
        end
        if (qed_uses_rs1(fmt) && instr[RS1_LSB + HALF_BIT]) begin
            legal = 1'b0;
        end
        if (qed_uses_rs2(fmt) && instr[RS2_LSB + HALF_BIT]) begin
            legal = 1'b0;
        end
        return legal;
    endfunction

    // x0 must stay x0, so only nonzero used fields move to the upper half.
    function automatic logic [31:0] qed_remap(input logic [31:0] instr);
        qed_fmt_e    fmt;
        logic [31:0] res;
        fmt = qed_fmt(instr);
        res = instr;
        if (qed_uses_rd(fmt) && (instr[RD_LSB +: REG_W] != '0)) begin
            res[RD_LSB + HALF_BIT] = 1'b1;
        end
        if (qed_uses_rs1(fmt) && (instr[RS1_LSB +: REG_W] != '0)) begin
            res[RS1_LSB + HALF_BIT] = 1'b1;
        end
        if (qed_uses_rs2(fmt) && (instr[RS2_LSB +: REG_W] != '0)) begin
            res[RS2_LSB + HALF_BIT] = 1'b1;
        end
        return res;
    endfunction

endpackage

// File: rtl/qed_fifo.sv
// Synchronous FIFO holding recorded originals; head is read combinationally from storage.
// Pointers and occupancy reset asynchronously, storage contents are left unreset.
module qed_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q,  count_d;
    logic             do_push;
    logic             do_pop;

    assign full      = (count_q == CNT_FULL);
    assign empty     = (count_q == '0);
    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;
    assign head_data = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/qed_instr_dup.sv
// SQED front-end duplicator: records legal originals and replays them with registers
// remapped into the upper half, driving the IF/ID instruction/valid pair.
module qed_instr_dup
    import qed_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      instruction,
    input  logic             qed_exec_dup,
    input  logic             stall,
    output logic [31:0]      qed_ifu_instruction,
    output logic             qed_vld_out,
    output logic [CNT_W-1:0] qed_num_orig,
    output logic [CNT_W-1:0] qed_num_dup,
    output logic             qed_check_ready
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [31:0]      instr_q,    instr_d;
    logic             vld_q,      vld_d;
    logic [CNT_W-1:0] num_orig_q, num_orig_d;
    logic [CNT_W-1:0] num_dup_q,  num_dup_d;

    qed_act_e    act;
    logic        orig_legal;
    logic        fifo_full;
    logic        fifo_empty;
    logic [31:0] fifo_head;

    assign orig_legal = qed_is_legal_orig(instruction);

    qed_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (act == ACT_PUSH),
        .push_data (instruction),
        .pop       (act == ACT_POP),
        .head_data (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Stall dominates; otherwise the mode picks push or pop, falling back to a bubble.
    always_comb begin
        act = ACT_HOLD;
        if (!stall) begin
            if (!qed_exec_dup) begin
                act = (orig_legal && !fifo_full) ? ACT_PUSH : ACT_BUBBLE;
            end else begin
                act = fifo_empty ? ACT_BUBBLE : ACT_POP;
            end
        end
    end

    always_comb begin
        instr_d    = instr_q;
        vld_d      = vld_q;
        num_orig_d = num_orig_q;
        num_dup_d  = num_dup_q;
        case (act)
            ACT_PUSH: begin
                instr_d    = instruction;
                vld_d      = 1'b1;
                num_orig_d = num_orig_q + CNT_ONE;
            end
            ACT_POP: begin
                instr_d   = qed_remap(fifo_head);
                vld_d     = 1'b1;
                num_dup_d = num_dup_q + CNT_ONE;
            end
            ACT_BUBBLE: begin
                instr_d = QED_NOP;
                vld_d   = 1'b0;
            end
            default: begin
                instr_d = instr_q;
                vld_d   = vld_q;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr_q    <= QED_NOP;
            vld_q      <= 1'b0;
            num_orig_q <= '0;
            num_dup_q  <= '0;
        end else begin
            instr_q    <= instr_d;
            vld_q      <= vld_d;
            num_orig_q <= num_orig_d;
            num_dup_q  <= num_dup_d;
        end
    end

    assign qed_ifu_instruction = instr_q;
    assign qed_vld_out         = vld_q;
    assign qed_num_orig        = num_orig_q;
    assign qed_num_dup         = num_dup_q;
    assign qed_check_ready     = (num_orig_q == num_dup_q) && (num_orig_q != '0) && fifo_empty;

endmodule

// File: tb/tb_qed_instr_dup.sv
// Self-checking bench for qed_instr_dup: directed scenarios plus a randomized phase,
// all compared against a queue-based reference model of the duplicator.
module tb_qed_instr_dup;

    localparam int DEPTH = 16;
    localparam int CNT_W = 16;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic             clk = 1'b0;
    logic             reset;
    logic [31:0]      instruction;
    logic             qed_exec_dup;
    logic             stall;
    logic [31:0]      qed_ifu_instruction;
    logic             qed_vld_out;
    logic [CNT_W-1:0] qed_num_orig;
    logic [CNT_W-1:0] qed_num_dup;
    logic             qed_check_ready;

    int checks = 0;
    int errors = 0;

    logic [31:0]      model_q[$];
    logic [31:0]      exp_instr;
    logic             exp_vld;
    logic [CNT_W-1:0] exp_orig;
    logic [CNT_W-1:0] exp_dup;

    always #5 clk = ~clk;

    qed_instr_dup #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .instruction         (instruction),
        .qed_exec_dup        (qed_exec_dup),
        .stall               (stall),
        .qed_ifu_instruction (qed_ifu_instruction),
        .qed_vld_out         (qed_vld_out),
        .qed_num_orig        (qed_num_orig),
        .qed_num_dup         (qed_num_dup),
        .qed_check_ready     (qed_check_ready)
    );

    function automatic bit has_rd(input logic [31:0] ins);
        return ins[6:0] == 7'b0110011 || ins[6:0] == 7'b0010011 || ins[6:0] == 7'b0000011;
    endfunction

    function automatic bit has_rs1(input logic [31:0] ins);
        return has_rd(ins) || ins[6:0] == 7'b0100011;
    endfunction

    function automatic bit has_rs2(input logic [31:0] ins);
        return ins[6:0] == 7'b0110011 || ins[6:0] == 7'b0100011;
    endfunction

    function automatic bit ref_legal(input logic [31:0] ins);
        int rd, rs1, rs2;
        rd  = int'(ins[11:7]);
        rs1 = int'(ins[19:15]);
        rs2 = int'(ins[24:20]);
        if (!has_rs1(ins)) return 1'b0;
        if (has_rd(ins) && rd >= 16) return 1'b0;
        if (rs1 >= 16) return 1'b0;
        if (has_rs2(ins) && rs2 >= 16) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [31:0] ref_remap(input logic [31:0] ins);
        logic [31:0] r;
        r = ins;
        if (has_rd(ins) && ins[11:7] != 5'd0)    r[11:7]  = ins[11:7] | 5'd16;
        if (has_rs1(ins) && ins[19:15] != 5'd0)  r[19:15] = ins[19:15] | 5'd16;
        if (has_rs2(ins) && ins[24:20] != 5'd0)  r[24:20] = ins[24:20] | 5'd16;
        return r;
    endfunction

    function automatic logic [31:0] gen_legal();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 3))
            0:       begin r[6:0] = 7'b0110011; r[11] = 1'b0; r[24] = 1'b0; end
            1:       begin r[6:0] = 7'b0010011; r[11] = 1'b0; end
            2:       begin r[6:0] = 7'b0000011; r[11] = 1'b0; end
            default: begin r[6:0] = 7'b0100011; r[24] = 1'b0; end
        endcase
        r[19] = 1'b0;
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic checkOutput(input string tag);
        logic exp_ready;
        exp_ready = (exp_orig == exp_dup) && (exp_orig != '0) && (model_q.size() == 0);
        check({tag, ".instr"}, qed_ifu_instruction, exp_instr);
        check({tag, ".vld"}, 32'(qed_vld_out), 32'(exp_vld));
        check({tag, ".num_orig"}, 32'(qed_num_orig), 32'(exp_orig));
        check({tag, ".num_dup"}, 32'(qed_num_dup), 32'(exp_dup));
        check({tag, ".ready"}, 32'(qed_check_ready), 32'(exp_ready));
    endtask

    task automatic model_reset();
        model_q.delete();
        exp_instr = NOP;
        exp_vld   = 1'b0;
        exp_orig  = '0;
        exp_dup   = '0;
    endtask

    task automatic model_step(input logic [31:0] ins, input logic dup, input logic stl);
        if (stl) return;
        if (!dup) begin
            if (ref_legal(ins) && model_q.size() < DEPTH) begin
                model_q.push_back(ins);
                exp_instr = ins;
                exp_vld   = 1'b1;
                exp_orig  = exp_orig + 1'b1;
            end else begin
                exp_instr = NOP;
                exp_vld   = 1'b0;
            end
        end else if (model_q.size() > 0) begin
            exp_instr = ref_remap(model_q.pop_front());
            exp_vld   = 1'b1;
            exp_dup   = exp_dup + 1'b1;
        end else begin
            exp_instr = NOP;
            exp_vld   = 1'b0;
        end
    endtask

    task automatic applyStimulus(input logic [31:0] ins, input logic dup, input logic stl,
                                 input string tag);
        instruction  = ins;
        qed_exec_dup = dup;
        stall        = stl;
        model_step(ins, dup, stl);
        @(posedge clk);
        #1;
        checkOutput(tag);
    endtask

    // Asynchronous reset raised away from any clock edge, checked before the next edge.
    task automatic doReset(input string tag);
        #3;
        reset = 1'b1;
        #1;
        model_reset();
        checkOutput(tag);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        reset        = 1'b1;
        instruction  = '0;
        qed_exec_dup = 1'b0;
        stall        = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        checkOutput("reset_initial");
        reset = 1'b0;

        applyStimulus(32'h002081B3, 1'b0, 1'b0, "add_orig");
        check("add_orig_lit", qed_ifu_instruction, 32'h002081B3);
        applyStimulus(32'h0, 1'b1, 1'b0, "add_dup");
        check("add_dup_lit", qed_ifu_instruction, 32'h012889B3);
        check("add_dup_ready_lit", 32'(qed_check_ready), 32'd1);

        applyStimulus(32'h00500013, 1'b0, 1'b0, "addi_x0_orig");
        applyStimulus(32'h0020A223, 1'b0, 1'b0, "sw_orig");
        applyStimulus(32'h0, 1'b1, 1'b0, "addi_x0_dup");
        check("addi_x0_dup_lit", qed_ifu_instruction, 32'h00500013);
        applyStimulus(32'h0, 1'b1, 1'b0, "sw_dup");
        check("sw_dup_lit", qed_ifu_instruction, 32'h0128A223);

        applyStimulus(32'h00208A33, 1'b0, 1'b0, "illegal_rd");
        check("illegal_rd_vld_lit", 32'(qed_vld_out), 32'd0);
        applyStimulus(32'h00208463, 1'b0, 1'b0, "illegal_branch");
        check("illegal_branch_lit", qed_ifu_instruction, NOP);

        doReset("reset_before_fill");
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(gen_legal(), 1'b0, 1'b0, "fill");
        end
        applyStimulus(gen_legal(), 1'b0, 1'b0, "fill_overflow");
        check("fill_overflow_vld_lit", 32'(qed_vld_out), 32'd0);
        check("fill_overflow_orig_lit", 32'(qed_num_orig), 32'd16);
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(32'h0, 1'b1, 1'b0, "drain");
        end
        applyStimulus(32'h0, 1'b1, 1'b0, "drain_empty");
        check("drain_empty_vld_lit", 32'(qed_vld_out), 32'd0);

        doReset("reset_before_stall");
        applyStimulus(gen_legal(), 1'b0, 1'b0, "stall_fill");
        applyStimulus(gen_legal(), 1'b0, 1'b0, "stall_fill");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(32'h0, 1'b1, 1'b1, "stall_hold");
        end
        check("stall_hold_dup_lit", 32'(qed_num_dup), 32'd0);
        applyStimulus(32'h0, 1'b1, 1'b0, "stall_release");
        applyStimulus(32'h0, 1'b1, 1'b0, "stall_release");

        for (int i = 0; i < 400; i++) begin
            logic [31:0] ins;
            logic        dup;
            logic        stl;
            ins = ($urandom_range(0, 3) == 0) ? 32'($urandom) : gen_legal();
            dup = ($urandom_range(0, 99) < 45);
            stl = ($urandom_range(0, 99) < 12);
            applyStimulus(ins, dup, stl, "random");
        end

        for (int i = 0; i < 3; i++) begin
            applyStimulus(gen_legal(), 1'b0, 1'b0, "pre_reset_fill");
        end
        doReset("reset_midstream");
        applyStimulus(32'h0, 1'b1, 1'b0, "post_reset_dup");
        check("post_reset_dup_vld_lit", 32'(qed_vld_out), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
